// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the iterative floating-point multiplier.
package fp_mul_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_EXP_W  = 8;

  typedef enum logic [1:0] {
    SPEC_NONE,
    SPEC_NAN,
    SPEC_INF,
    SPEC_ZERO
  } spec_e;

  // Subnormals arrive here already merged into the zero flags, so INF x subnormal is invalid.
  function automatic spec_e resolve_special(input logic nan_a, input logic inf_a, input logic zero_a,
                                            input logic nan_b, input logic inf_b, input logic zero_b);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return SPEC_NAN;
    if (inf_a || inf_b) return SPEC_INF;
    if (zero_a || zero_b) return SPEC_ZERO;
    return SPEC_NONE;
  endfunction

endpackage

// File: rtl/fp_special.sv
// Classifies the magnitude of an IEEE-754 operand (sign bit not needed).
module fp_special #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-2:0] mag,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero,
  output logic              is_sub
);
  localparam int FRAC_W = DATA_W - EXP_W - 1;

  logic exp_ones, exp_zero, frac_zero;

  assign exp_ones  = &mag[DATA_W-2 -: EXP_W];
  assign exp_zero  = ~|mag[DATA_W-2 -: EXP_W];
  assign frac_zero = ~|mag[FRAC_W-1:0];

  assign is_nan  = exp_ones & ~frac_zero;
  assign is_inf  = exp_ones & frac_zero;
  assign is_zero = exp_zero & frac_zero;
  assign is_sub  = exp_zero & ~frac_zero;
endmodule

// File: rtl/mul_shiftadd.sv
// Sequential unsigned shift-add multiplier: retires one multiplier bit per cycle, LSB first.
module mul_shiftadd #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic [2*DATA_W-1:0]   product,
  output logic                  done
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DATA_W:0]     sum;

  // Upper half accumulates partial sums; lower half holds the multiplier bits not yet retired.
  always_comb begin
    sum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start) begin
      acc_d   = {{DATA_W{1'b0}}, multiplier};
      mcand_d = multiplicand;
      cnt_d   = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      acc_d  = {sum, acc_q[DATA_W-1:1]};
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign product = acc_q;
  assign done    = done_q;
endmodule

// File: rtl/round.sv
// Round-to-nearest-even of a mantissa carrying guard, round and sticky bits in its low three bits.
module round #(
  parameter int MAN_W = 24
) (
  input  logic [MAN_W+2:0] man_grs,
  output logic [MAN_W-1:0] man_out,
  output logic             carry
);
  logic inc;

  // Round up above the halfway point, or exactly at it when the kept LSB is odd.
  assign inc = man_grs[2] & (man_grs[1] | man_grs[0] | man_grs[3]);
  assign {carry, man_out} = {1'b0, man_grs[MAN_W+2:3]} + (MAN_W+1)'(inc);
endmodule

// File: rtl/fp_mul.sv
// Iterative IEEE-754 multiplier: capture, shift-add mantissa product, normalize/round, output register.
module fp_mul
  import fp_mul_pkg::*;
#(
  parameter int DATA_W = FP_DATA_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              exception
);
  localparam int MAN_W = DATA_W - EXP_W;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int LAT   = MAN_W + 3;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam int EW    = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_MIN = '0;
  localparam logic [DATA_W-1:0]    NAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-2){1'b0}}};

  logic nan_a, inf_a, zero_a, sub_a, nan_b, inf_b, zero_b, sub_b;

  fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_spec_a (
    .mag(op_a[DATA_W-2:0]), .is_nan(nan_a), .is_inf(inf_a), .is_zero(zero_a), .is_sub(sub_a));
  fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_spec_b (
    .mag(op_b[DATA_W-2:0]), .is_nan(nan_b), .is_inf(inf_b), .is_zero(zero_b), .is_sub(sub_b));

  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [MAN_W-1:0]     man_a_q, man_a_d, man_b_q, man_b_d;
  spec_e                spec_q, spec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Counter idles at LAT; any start (even mid-operation) recaptures operands and restarts at 0.
  always_comb begin
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_a_d = man_a_q;
    man_b_d = man_b_q;
    spec_d  = spec_q;
    cnt_d   = cnt_q;
    if (start) begin
      sign_d  = op_a[DATA_W-1] ^ op_b[DATA_W-1];
      exp_d   = EW'(op_a[DATA_W-2 -: EXP_W]) + EW'(op_b[DATA_W-2 -: EXP_W]) - EW'(BIAS);
      man_a_d = {1'b1, op_a[MAN_W-2:0]};
      man_b_d = {1'b1, op_b[MAN_W-2:0]};
      spec_d  = resolve_special(nan_a, inf_a, zero_a | sub_a, nan_b, inf_b, zero_b | sub_b);
      cnt_d   = '0;
    end else if (cnt_q != CNT_W'(LAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  logic                mul_start, mul_done;
  logic [2*MAN_W-1:0]  prod;

  assign mul_start = (cnt_q == '0);

  mul_shiftadd #(.DATA_W(MAN_W)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .multiplicand(man_a_q), .multiplier(man_b_q),
    .product(prod), .done(mul_done));

  logic [2*MAN_W-1:0]   norm;
  logic [MAN_W+2:0]     grs;
  logic [MAN_W-1:0]     man_r;
  logic                 rnd_carry;
  logic signed [EW-1:0] exp_n, exp_r;
  logic                 unused_hidden;

  // Align the leading one to the top bit; every bit below the round position folds into sticky.
  assign norm  = prod[2*MAN_W-1] ? prod : (prod << 1);
  assign grs   = {norm[2*MAN_W-1 -: MAN_W+2], |norm[MAN_W-3:0]};
  assign exp_n = exp_q + EW'(prod[2*MAN_W-1]);
  assign exp_r = exp_n + EW'(rnd_carry);
  assign unused_hidden = man_r[MAN_W-1];

  round #(.MAN_W(MAN_W)) u_round (.man_grs(grs), .man_out(man_r), .carry(rnd_carry));

  logic [DATA_W-1:0] pre_res_q, pre_res_d;
  logic              pre_ovf_q, pre_ovf_d, pre_unf_q, pre_unf_d, pre_exc_q, pre_exc_d;

  always_comb begin
    pre_res_d = pre_res_q;
    pre_ovf_d = pre_ovf_q;
    pre_unf_d = pre_unf_q;
    pre_exc_d = pre_exc_q;
    if (mul_done) begin
      pre_ovf_d = 1'b0;
      pre_unf_d = 1'b0;
      pre_exc_d = 1'b0;
      case (spec_q)
        SPEC_NAN: begin
          pre_res_d = NAN;
          pre_exc_d = 1'b1;
        end
        SPEC_INF:  pre_res_d = {sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
        SPEC_ZERO: pre_res_d = {sign_q, {(DATA_W-1){1'b0}}};
        default: begin
          if (exp_r >= EXP_MAX) begin
            pre_res_d = {sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
            pre_ovf_d = 1'b1;
          end else if (exp_r <= EXP_MIN) begin
            pre_res_d = {sign_q, {(DATA_W-1){1'b0}}};
            pre_unf_d = 1'b1;
          end else begin
            pre_res_d = {sign_q, exp_r[EXP_W-1:0], man_r[MAN_W-2:0]};
          end
        end
      endcase
    end
  end

  logic              done_q, done_d, ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d;
  logic [DATA_W-1:0] res_q, res_d;

  // The final edge completes even if a new start lands on it, allowing issue every LAT cycles.
  always_comb begin
    done_d = (cnt_q == CNT_W'(LAT-1));
    res_d  = done_d ? pre_res_q : res_q;
    ovf_d  = done_d ? pre_ovf_q : ovf_q;
    unf_d  = done_d ? pre_unf_q : unf_q;
    exc_d  = done_d ? pre_exc_q : exc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q    <= 1'b0;
      exp_q     <= '0;
      man_a_q   <= '0;
      man_b_q   <= '0;
      spec_q    <= SPEC_NONE;
      cnt_q     <= CNT_W'(LAT);
      pre_res_q <= '0;
      pre_ovf_q <= 1'b0;
      pre_unf_q <= 1'b0;
      pre_exc_q <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      man_a_q   <= man_a_d;
      man_b_q   <= man_b_d;
      spec_q    <= spec_d;
      cnt_q     <= cnt_d;
      pre_res_q <= pre_res_d;
      pre_ovf_q <= pre_ovf_d;
      pre_unf_q <= pre_unf_d;
      pre_exc_q <= pre_exc_d;
      done_q    <= done_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      exc_q     <= exc_d;
    end
  end

  assign done      = done_q;
  assign res       = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;
endmodule
